halfband_decimator: RTL
=======================

# halfband_decimator

Second decimation stage that follows the CIC decimation filter. It consumes the CIC's 24-bit output samples, which arrive once per divided-clock period. It applies a 15-tap half-band FIR that compensates droop and rejects aliases, then decimates by 2. It uses a single time-shared multiply-accumulate, and its 16-bit result drives the chip's `uo_out`/`uio_out` pins.

## Interface
- `DATA_W`, default 24: input sample width, signed two's complement.
- `OUT_W`, default 16: output sample width, signed.
- `SHIFT`, default 11: right-shift applied to the accumulator before saturation.
- `clk`, in, 1: system clock, the same undivided clock the CIC uses.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `in_valid`, in, 1: one-cycle strobe marking a new CIC sample.
- `in_data`, in, DATA_W: CIC output sample, sampled when `in_valid`=1.
- `out_valid`, out, 1: one-cycle strobe marking a new decimated sample.
- `out_data`, out, OUT_W: decimated sample; holds its value between strobes.
- `busy`, out, 1: high while the MAC sequence runs.
- `overrun`, out, 1: sticky error flag, cleared only by `rst`.

## Operation
- **Sample buffer.** 16-entry circular buffer with a 4-bit write pointer.
  - Every `in_valid` writes `in_data` at the pointer, then increments the pointer (wraps 15→0).
  - The spare 16th slot lets a new sample be written while a MAC is in progress without corrupting its 15-sample window.
- **Phase bit.**
  - Toggles on every accepted sample and resets to 0.
  - A sample accepted with phase=1 (the 2nd, 4th, … after reset) triggers a MAC.
- **Filter equation.** y[n] = Σ h[k]·x[n−k], k=0..14, where x[n] is the triggering sample.
- **Coefficients** (COEF_W=12, signed, sum 2048 = unity gain): 4, 0, −24, 0, 88, 0, 444, 1024, 444, 0, 88, 0, −24, 0, 4.
- **FSM states.**
  - IDLE → MAC on a triggering `in_valid`. At that edge, latch base = write pointer and clear the accumulator.
  - MAC: counter k runs 0..14; each cycle acc += h[k]·buf[base−k mod 16]. Zero taps are still iterated, so latency is fixed. MAC → ROUND after k=14.
  - ROUND: out_data = sat(OUT_W, (acc + 2^(SHIFT−1)) >>> SHIFT), with round-half-up and arithmetic shift. Pulse `out_valid`, then → IDLE.
- **Widths.**
  - Accumulator ACC_W = DATA_W+COEF_W+4 = 40 bits; it cannot overflow.
  - Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **`busy`.** High in MAC and ROUND.
- **Overrun.**
  - A triggering `in_valid` that arrives while `busy`=1 still writes the buffer and toggles phase.
  - That MAC is skipped: no `out_valid` for it, and `overrun` is set to 1.
  - A non-triggering `in_valid` during `busy` is normal, not an overrun.
- **Reset.** While `rst`=1:
  - All buffer entries, the pointer, phase, accumulator, `out_data`, `out_valid`, `busy` and `overrun` go to 0; the FSM goes to IDLE.
  - Reset during MAC or ROUND aborts the sequence; no `out_valid` follows.

## Timing
- Edge E0 samples the triggering `in_valid` and `in_data`.
- Edges E1–E15 perform the 15 accumulates.
- Edge E16 registers `out_data` and `out_valid`=1.
- `out_valid` is high during the 17th cycle after the `in_valid` cycle, for exactly one cycle.
- `busy` is high for cycles 1..16 after the trigger.
- Minimum trigger spacing without overrun is 17 cycles. Behind the ÷64 clock divider the actual spacing is 128 cycles.
- `out_data` changes only on the `out_valid` edge.

## Structure
- Package `dsp_pkg` holds:
  - constants NTAPS=15, COEF_W=12, ACC_W;
  - the coefficient array `HB_COEF`;
  - the FSM state enum {IDLE, MAC, ROUND}.
- Sub-module `hb_sample_buf`: 16×DATA_W circular buffer with a synchronous write port, an asynchronous read port at an offset from base, and the wrapping pointer.
- The MAC, FSM, rounding and saturation live in `halfband_decimator`.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-MAC.
  - Expect all outputs 0 and no `out_valid` afterwards.
  - The first post-reset trigger is the 2nd `in_valid`.
- **Impulse:** samples 0, 2048, then zeros, spaced 64 cycles.
  - Expect successive outputs 4, −24, 88, 444, 444, 88, −24, 4, then 0.
- **DC step:** constant `in_data`=1000.
  - After 8 outputs, `out_data`=1000 every output.
  - −1000 gives −1000.
- **Saturation:**
  - Constant 8388607 → `out_data`=32767.
  - Constant −8388608 → −32768.
- **Latency:** check `out_valid` rises exactly 17 cycles after each triggering `in_valid`, and `busy` is high for 16 cycles.
- **Overrun:** triggers spaced 6 cycles apart.
  - Expect `overrun`=1, staying high until `rst`.
  - One `out_valid` is missing; the buffer contents still match a reference model on the next clean output.

Source files
------------

// File: rtl/dsp_pkg.sv
`default_nettype none
// dsp_pkg: shared constants, half-band coefficients and FSM encoding for the decimation chain.
// Revision 1.0
package dsp_pkg;

  localparam int NTAPS  = 15;
  localparam int COEF_W = 12;
  localparam int ACC_W  = 24 + COEF_W + 4;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric half-band taps; they sum to 2048, so SHIFT=11 restores unity gain.
  localparam coef_t HB_COEF [NTAPS] = '{
    12'sd4,   12'sd0, -12'sd24, 12'sd0, 12'sd88, 12'sd0, 12'sd444, 12'sd1024,
    12'sd444, 12'sd0,  12'sd88, 12'sd0, -12'sd24, 12'sd0, 12'sd4
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } hb_state_t;

endpackage
`default_nettype wire

// File: rtl/hb_sample_buf.sv
`default_nettype none
// hb_sample_buf: 16-entry circular sample store, synchronous write, asynchronous read at base-offset.
// Revision 1.0
module hb_sample_buf #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        base,
  input  logic [3:0]        offset,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        wr_ptr
);

  logic [DATA_W-1:0] mem [16];
  logic [3:0]        rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 4'd0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 4'd1;
    end
  end

  // Modulo-16 subtraction walks backwards in time from the newest sample.
  assign rd_addr = base - offset;
  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/halfband_decimator.sv
`default_nettype none
// halfband_decimator: 15-tap half-band FIR with decimate-by-2 using one time-shared MAC.
// Revision 1.0
module halfband_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              overrun
);

  localparam int AW = DATA_W + COEF_W + 4;
  localparam logic signed [AW-1:0] RND     = {{(AW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  hb_state_t state, state_nxt;

  logic [3:0]           wr_ptr;
  logic [3:0]           base;
  logic [3:0]           k;
  logic                 phase;
  logic                 trigger;
  logic                 last_tap;
  logic [DATA_W-1:0]    rd_data;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] coef_ext;
  logic signed [AW-1:0] samp_ext;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] shifted;
  logic [OUT_W-1:0]     sat_val;

  hb_sample_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .base    (base),
    .offset  (k),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr)
  );

  assign trigger  = in_valid && phase;
  assign last_tap = (k == 4'(NTAPS - 1));
  assign busy     = (state != IDLE);

  assign coef_ext = AW'(HB_COEF[k]);
  assign samp_ext = AW'($signed(rd_data));
  assign prod     = coef_ext * samp_ext;
  assign rounded  = acc + RND;
  assign shifted  = rounded >>> SHIFT;

  always_comb begin
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= 4'd0;
      k         <= 4'd0;
      phase     <= 1'b0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        phase <= ~phase;
      end
      // A trigger while busy keeps its sample but loses its MAC.
      if (trigger && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            base <= wr_ptr;
            acc  <= '0;
            k    <= 4'd0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= last_tap ? 4'd0 : k + 4'd1;
        end
        ROUND: begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
        end
        default: begin
          k <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
